// File: rtl/dcm_pkg.sv
// ============================================================================
// Module      : dcm_pkg
// Description : Shared types and helpers for the multi-channel clock manager:
//               default code width, counter sizing, half-period computation
//               and the per-channel RUN/PEND state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dcm_pkg;

  localparam int c_cfg_w_def = 3;

  // A channel is either running with no request outstanding, or holding a
  // shadowed code that waits for the next full-period boundary.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } ch_state_e;

  // Counter must reach BASE_DIV << (2**cfg_w - 1) minus one.
  function automatic int cnt_width(input int base_div, input int cfg_w);
    return $clog2(base_div) + (2 ** cfg_w) - 1;
  endfunction

  // Half-period in system clock cycles for a given divide code.
  function automatic int unsigned half_cycles(input int unsigned base_div,
                                              input int unsigned code);
    return base_div << code;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dcm_channel.sv
// ============================================================================
// Module      : dcm_channel
// Description : One divided-clock channel: half-period counter, output flop,
//               active and shadow code registers and the pending flag. A new
//               code is applied only on the falling edge that ends a full
//               period, so the output never produces a runt pulse.
//               Optional lock indication when DCM_MULTI_LOCK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcm_channel
  import dcm_pkg::*;
#(
  parameter int BASE_DIV   = 500,
  parameter int CFG_W      = c_cfg_w_def,
  parameter int RESET_CODE = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             upd_i,
  input  logic [CFG_W-1:0] code_i,
  output logic             clk_o,
  output logic             pend_o,
`ifdef DCM_MULTI_LOCK_EN
  output logic             lock_o,
`endif
  output logic [CFG_W-1:0] active_o
);

  localparam int c_cnt_w = cnt_width(BASE_DIV, CFG_W);

  ch_state_e          state_q, state_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic               clk_q, clk_d;
  logic [CFG_W-1:0]   active_q, active_d;
  logic [CFG_W-1:0]   shadow_q, shadow_d;
  logic [c_cnt_w-1:0] w_half_m1;
  logic               w_tc;
  logic               w_apply;

  assign w_half_m1 = c_cnt_w'(half_cycles(BASE_DIV, 32'(active_q)) - 32'd1);
  assign w_tc      = (cnt_q == w_half_m1);
  // Apply only on the falling edge that closes a full high/low period.
  assign w_apply   = (state_q == ST_PEND) && w_tc && clk_q;

  // Next-state: counting, toggling, apply of the shadow and request latching.
  always_comb begin
    state_d  = state_q;
    cnt_d    = w_tc ? '0 : cnt_q + c_cnt_w'(1);
    clk_d    = w_tc ? ~clk_q : clk_q;
    active_d = active_q;
    shadow_d = shadow_q;
    if (w_apply) begin
      active_d = shadow_q;
      state_d  = ST_RUN;
    end
    // A request on the apply edge keeps the channel pending with the new code.
    if (upd_i) begin
      shadow_d = code_i;
      state_d  = ST_PEND;
    end
  end

  // Channel state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_RUN;
      cnt_q    <= '0;
      clk_q    <= 1'b0;
      active_q <= CFG_W'(RESET_CODE);
      shadow_q <= CFG_W'(RESET_CODE);
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      clk_q    <= clk_d;
      active_q <= active_d;
      shadow_q <= shadow_d;
    end
  end

  assign clk_o    = clk_q;
  assign pend_o   = (state_q == ST_PEND);
  assign active_o = active_q;

`ifdef DCM_MULTI_LOCK_EN
  logic lock_q, lock_d;

  // Lock sets at the end of a full period with nothing pending, clears on any
  // request or apply.
  always_comb begin
    lock_d = lock_q;
    if (upd_i || w_apply || (state_q == ST_PEND)) begin
      lock_d = 1'b0;
    end else if (w_tc && clk_q) begin
      lock_d = 1'b1;
    end
  end

  // Lock flag register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lock_q <= 1'b0;
    end else begin
      lock_q <= lock_d;
    end
  end

  assign lock_o = lock_q;
`endif

endmodule

`default_nettype wire

// File: rtl/dcm_multi.sv
// ============================================================================
// Module      : dcm_multi
// Description : Multi-channel digital clock manager. Decodes channel-select
//               for update requests, instantiates NUM_CH dcm_channel blocks,
//               OR-reduces pending flags into busy and muxes the active code
//               of the selected channel onto prog_out.
//               Optional macro DCM_MULTI_LOCK_EN adds the locked output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcm_multi
  import dcm_pkg::*;
#(
  parameter int    BASE_DIV   = 500,
  parameter int    NUM_CH     = 2,
  parameter int    CFG_W      = c_cfg_w_def,
  parameter int    RESET_CODE = 0,
  localparam int   SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              update_clock,
  input  logic [SEL_W-1:0]  ch_sel,
  input  logic [CFG_W-1:0]  prog_in,
  output logic [CFG_W-1:0]  prog_out,
  output logic              busy,
`ifdef DCM_MULTI_LOCK_EN
  output logic [NUM_CH-1:0] locked,
`endif
  output logic [NUM_CH-1:0] clock_out
);

  logic [NUM_CH-1:0] w_upd;
  logic [NUM_CH-1:0] w_pend;
  logic [CFG_W-1:0]  w_active [NUM_CH];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    // Out-of-range selects match no channel and are therefore ignored.
    assign w_upd[k] = update_clock && (ch_sel == SEL_W'(k));

    dcm_channel #(
      .BASE_DIV   (BASE_DIV),
      .CFG_W      (CFG_W),
      .RESET_CODE (RESET_CODE)
    ) u_ch (
      .clock    (clock),
      .reset    (reset),
      .upd_i    (w_upd[k]),
      .code_i   (prog_in),
      .clk_o    (clock_out[k]),
      .pend_o   (w_pend[k]),
`ifdef DCM_MULTI_LOCK_EN
      .lock_o   (locked[k]),
`endif
      .active_o (w_active[k])
    );
  end

  // Pending flags are registered, so busy follows a request by one cycle.
  assign busy = |w_pend;

  // Read-back mux of applied codes; unselected or invalid channel reads zero.
  always_comb begin
    prog_out = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == SEL_W'(i)) begin
        prog_out = w_active[i];
      end
    end
  end

endmodule

`default_nettype wire
